lfsr_keystream_ctrl: RTL



---
 rtl/lfsr_keystream_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_keystream_ctrl.sv
// lfsr_keystream_ctrl
// Sequences an external 16-bit LFSR keystream generator: seed load, warm-up
// discard, then one generator step per data bit while a plaintext word is
// XORed LSB first into ciphertext.
//
// Handshakes (seed, in, out) use strict valid/ready semantics: a transfer
// happens at a rising clk edge where valid and ready are both high. Valid
// must not depend on ready. Ready may depend on the current state only.
module lfsr_keystream_ctrl #(
  parameter int DATA_W        = 8,
  parameter int WARMUP_CYCLES = 32,
  parameter int REKEY_LIMIT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  input  logic [15:0]       seed,
  output logic              seed_ready,
  output logic              seed_err,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ks_load,
  output logic [15:0]       ks_seed,
  output logic              ks_step,
  input  logic              ks_bit,
  output logic              rekey_req,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    ST_UNSEEDED = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WARMUP   = 3'd2,
    ST_READY    = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_HOLD     = 3'd5
  } state_e;

  localparam int BIW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_W - 1);
  localparam logic [15:0]    WARM_INIT = (WARMUP_CYCLES > 0) ? 16'(WARMUP_CYCLES - 1) : 16'd0;
  localparam logic [15:0]    REKEY_VAL = 16'(REKEY_LIMIT);

  state_e            state_q, state_d;
  logic [15:0]       seed_q, seed_d;
  logic              seed_err_q, seed_err_d;
  logic [15:0]       warm_cnt_q, warm_cnt_d;
  logic [BIW-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              rekey_q, rekey_d;

  logic              seed_fire;
  logic              seed_ok;
  logic              seed_zero;
  logic              word_fire;
  logic              out_fire;
  logic [15:0]       count_inc;

  // Handshake qualifiers; a nonzero seed in READY wins over a plaintext word.
  always_comb begin
    seed_fire = seed_valid && ((state_q == ST_UNSEEDED) || (state_q == ST_READY));
    seed_ok   = seed_fire && (seed != 16'd0);
    seed_zero = seed_fire && (seed == 16'd0);
    word_fire = (state_q == ST_READY) && !rekey_q && in_valid && !seed_ok;
    out_fire  = (state_q == ST_HOLD) && out_ready;
    count_inc = (word_count_q == 16'hFFFF) ? word_count_q : word_count_q + 16'd1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNSEEDED;
      seed_q       <= 16'd0;
      seed_err_q   <= 1'b0;
      warm_cnt_q   <= 16'd0;
      bit_idx_q    <= '0;
      data_q       <= '0;
      word_count_q <= 16'd0;
      rekey_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      seed_err_q   <= seed_err_d;
      warm_cnt_q   <= warm_cnt_d;
      bit_idx_q    <= bit_idx_d;
      data_q       <= data_d;
      word_count_q <= word_count_d;
      rekey_q      <= rekey_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNSEEDED: if (seed_ok) state_d = ST_LOAD;
      ST_LOAD:     state_d = (WARMUP_CYCLES == 0) ? ST_READY : ST_WARMUP;
      ST_WARMUP:   if (warm_cnt_q == 16'd0) state_d = ST_READY;
      ST_READY: begin
        if (seed_ok)        state_d = ST_LOAD;
        else if (word_fire) state_d = ST_SHIFT;
      end
      ST_SHIFT:    if (bit_idx_q == LAST_BIT) state_d = ST_HOLD;
      ST_HOLD:     if (out_ready) state_d = ST_READY;
      default:     state_d = ST_UNSEEDED;
    endcase
  end

  // Datapath next values: seed latch, warm-up counter, in-place XOR, counters.
  always_comb begin
    seed_d       = seed_q;
    seed_err_d   = seed_err_q | seed_zero;
    warm_cnt_d   = warm_cnt_q;
    bit_idx_d    = bit_idx_q;
    data_d       = data_q;
    word_count_d = word_count_q;
    rekey_d      = rekey_q;
    if (seed_ok) seed_d = seed;
    if (state_q == ST_LOAD) begin
      warm_cnt_d   = WARM_INIT;
      word_count_d = 16'd0;
      rekey_d      = 1'b0;
    end
    if ((state_q == ST_WARMUP) && (warm_cnt_q != 16'd0)) warm_cnt_d = warm_cnt_q - 16'd1;
    if (word_fire) begin
      data_d    = in_data;
      bit_idx_d = '0;
    end
    // Plaintext bit i is overwritten by its ciphertext bit in shift cycle i.
    if (state_q == ST_SHIFT) begin
      data_d[bit_idx_q] = data_q[bit_idx_q] ^ ks_bit;
      bit_idx_d         = bit_idx_q + BIW'(1);
    end
    if (out_fire) begin
      word_count_d = count_inc;
      if ((REKEY_LIMIT != 0) && (count_inc == REKEY_VAL)) rekey_d = 1'b1;
    end
  end

  // Outputs decoded from state; generator controls are suppressed during reset.
  always_comb begin
    seed_ready = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ks_load    = 1'b0;
    ks_step    = 1'b0;
    unique case (state_q)
      ST_UNSEEDED: seed_ready = 1'b1;
      ST_LOAD:     ks_load    = !reset;
      ST_WARMUP:   ks_step    = !reset;
      ST_READY: begin
        seed_ready = 1'b1;
        in_ready   = !rekey_q;
      end
      ST_SHIFT:    ks_step    = !reset;
      ST_HOLD:     out_valid  = 1'b1;
      default:     seed_ready = 1'b0;
    endcase
    ks_seed    = seed_q;
    out_data   = data_q;
    seed_err   = seed_err_q;
    rekey_req  = rekey_q;
    word_count = word_count_q;
  end

endmodule
